// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - word RAM responder with programmable wait states and valid/ready response
// Optional macro DMEM_OOR_ERR_EN: out-of-range addresses get an error response instead of wrapping.
module data_mem_responder #(
  parameter int AW          = 16,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_write,
  output logic          rsp_err,
  output logic          busy
);
  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state;
  logic [31:0]   mem [DEPTH];
  logic          h_write;
  logic [AW-1:0] h_addr;
  logic [31:0]   h_wdata;
  logic [3:0]    cnt;

  logic          accept;
  logic          do_access;
  logic          a_write;
  logic          a_oor;
  logic [AW-1:0] a_addr;
  logic [31:0]   a_wdata;
  logic [31:0]   a_rdata;
  logic [IW-1:0] a_idx;

  // With zero wait states the access happens on the acceptance edge, straight from the request inputs.
  always_comb begin
    accept    = (state == IDLE) && req_valid;
    do_access = (accept && (WAIT_STATES == 0)) || ((state == WAIT) && (cnt <= 4'd1));
    a_write   = (state == IDLE) ? req_write : h_write;
    a_addr    = (state == IDLE) ? req_addr  : h_addr;
    a_wdata   = (state == IDLE) ? req_wdata : h_wdata;
    a_idx     = a_addr[IW-1:0];
    if (a_write)
      a_rdata = 32'h0;
    else if (a_oor)
      a_rdata = 32'hDEADBEEF;
    else
      a_rdata = mem[a_idx];
  end

`ifdef DMEM_OOR_ERR_EN
  assign a_oor = 32'(a_addr) >= 32'(DEPTH);
`else
  logic unused_addr_hi;
  assign a_oor          = 1'b0;
  assign unused_addr_hi = ^a_addr;
`endif

  // RAM is not reset; a reset in progress blocks any pending store.
  always_ff @(posedge clock) begin
    if (reset && do_access && a_write && !a_oor)
      mem[a_idx] <= a_wdata;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_write <= 1'b0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      cnt       <= 4'd0;
      h_write   <= 1'b0;
      h_addr    <= '0;
      h_wdata   <= 32'h0;
    end else begin
      if (do_access) begin
        state     <= RESP;
        rsp_valid <= 1'b1;
        rsp_write <= a_write;
        rsp_rdata <= a_rdata;
        rsp_err   <= a_oor;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            h_write   <= req_write;
            h_addr    <= req_addr;
            h_wdata   <= req_wdata;
            cnt       <= 4'(WAIT_STATES);
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (WAIT_STATES != 0)
              state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt > 4'd1)
            cnt <= cnt - 4'd1;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the load/store path. The EX stage is the initiator and issues word read/write requests. This block completes them after a programmable number of wait states and returns a response through a valid/ready handshake.
- Replaces the zero-latency data memory so the pipeline can be exercised against a slow memory.
- Holds a word-addressed 32-bit RAM internally.

Parameters:
- AW, 16, request address width (word address)
- DEPTH, 1024, number of 32-bit words; power of two, DEPTH <= 2^AW
- WAIT_STATES, 2, extra cycles between acceptance and response; 0..15

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  active-low asynchronous reset
- req_valid  input  1  initiator has a request
- req_ready  output  1  responder can accept a request
- req_write  input  1  1 = store, 0 = load
- req_addr  input  AW  word address
- req_wdata  input  32  store data
- rsp_valid  output  1  response available
- rsp_ready  input  1  initiator accepts response
- rsp_rdata  output  32  load data; 0 for store responses
- rsp_write  output  1  echo of req_write for the transaction
- rsp_err  output  1  error flag (see Optional Feature)
- busy  output  1  transaction in flight (state != IDLE)

Behaviour:
- Reset: one clock domain; reset is asynchronous and active-low. While reset=0:
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_write=0, rsp_err=0, busy=0, wait counter=0.
  - RAM contents are not cleared by reset. Simulation initialises the RAM to all zeros at time 0.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid & req_ready, latch req_write, req_addr and req_wdata into holding registers, load counter=WAIT_STATES, and go to WAIT.
  - If WAIT_STATES=0, go directly to RESP instead.
- WAIT:
  - req_ready=0. The counter decrements each cycle.
  - When the counter reaches 1 (or on entry with 0 remaining), perform the access on that edge and move to RESP on the next edge.
- Access in the IDLE/WAIT to RESP transition edge:
  - Store: RAM[addr] <= wdata, rsp_rdata <= 0.
  - Load: rsp_rdata <= RAM[addr].
  - rsp_valid <= 1 and rsp_write <= latched write.
- Latency: acceptance edge to rsp_valid high = WAIT_STATES+1 cycles.
- RESP:
  - rsp_valid=1, req_ready=0.
  - rsp_rdata, rsp_write and rsp_err are held stable until rsp_ready=1.
  - On rsp_valid & rsp_ready: rsp_valid <= 0, go to IDLE. rsp_rdata holds its last value.
  - Throughput limit: one transaction per WAIT_STATES+2 cycles minimum. No back-to-back acceptance in the RESP handshake cycle.
- Read-after-write: a load issued after a store response to the same address returns the new data.
- Request signals are only sampled at acceptance; changes while in WAIT/RESP are ignored.
- Reset asserted mid-transaction:
  - Transaction aborted and the FSM goes to IDLE.
  - A store that has not reached its access edge is not written.
  - A store already written stays written.
- Address indexing: RAM index = req_addr[log2(DEPTH)-1:0].

Optional Feature:
- Macro DMEM_OOR_ERR_EN.
- Defined:
  - A request with req_addr >= DEPTH is accepted and waits normally.
  - At the access edge a store is suppressed (RAM unchanged), and a load returns rsp_rdata=32'hDEADBEEF.
  - rsp_err=1 for that response.
  - In-range requests give rsp_err=0.
- Undefined:
  - The address wraps modulo DEPTH and the access is performed at the wrapped index.
  - rsp_err is tied to 0.

Test Plan:
- Reset/idle: reset=0 for 3 cycles, then release -> req_ready=1, rsp_valid=0, busy=0, rsp_rdata=0.
- Store then load, WAIT_STATES=2, rsp_ready=1:
  - Store addr 5, data 32'h12345678 -> rsp_valid 3 cycles after acceptance, rsp_write=1, rsp_rdata=0.
  - Then load addr 5 -> rsp_rdata=32'h12345678, rsp_write=0.
- Backpressure: load with rsp_ready=0 for 4 cycles after rsp_valid -> rsp_valid and rsp_rdata stable, req_ready=0 throughout. Raise rsp_ready -> req_ready=1 on the next cycle.
- WAIT_STATES=0: load addr 7, previously written 32'hA5A5A5A5 -> rsp_valid exactly 1 cycle after acceptance.
- Reset mid-op: store addr 9, 32'hFFFF0000, assert reset during WAIT, release, then load addr 9 -> 32'h00000000.
- Out of range, DEPTH=1024:
  - Store addr 1024, 32'h1 with the macro -> rsp_err=1, RAM[0] unchanged; load addr 1024 -> 32'hDEADBEEF, rsp_err=1.
  - Without the macro -> store lands at addr 0; load addr 0 returns 32'h1, rsp_err=0.
